booth_mult_seq: RTL and testbench

Parametrised sequential Booth multiplier. It is the next generation of the team's fixed 4-bit radix-2 Booth datapath (A/Q/M registers, adder, control unit). It adds parametric width, a signed/unsigned mode, and a start/busy/done handshake with a held result. It sits beside the ALU as a multi-cycle multiply unit, with one operation in flight at a time.

---
 rtl/booth_pkg.sv | 60 ++++++
 rtl/booth_mult_seq_if.sv | 35 +++
 rtl/booth_addsub.sv | 53 +++++
 rtl/booth_mult_seq.sv | 142 ++++++++++++++
 tb/tb_booth_mult_seq.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/booth_pkg.sv
// booth_pkg: shared types and helpers for the sequential Booth multiplier.
//   state_t     - control FSM encoding (IDLE, RUN, DONE)
//   r2_sel_t    - radix-2 Booth select codes, decoded from {Q[0], q_1}
//   r4_dig_t    - radix-4 (modified Booth) digit codes, decoded from {Q[1], Q[0], q_1}
//   iter_count  - number of RUN iterations for a given operand width and radix
// Optional feature macro: BOOTH_RADIX4_EN (selects the radix-4 datapath).
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    R2_NOP = 2'd0,
    R2_ADD = 2'd1,
    R2_SUB = 2'd2
  } r2_sel_t;

  typedef enum logic [2:0] {
    R4_ZERO = 3'd0,
    R4_ADD1 = 3'd1,
    R4_ADD2 = 3'd2,
    R4_SUB1 = 3'd3,
    R4_SUB2 = 3'd4
  } r4_dig_t;

  // 01 -> end of a run of ones seen from the right: add M.
  // 10 -> start of a run of ones: subtract M.
  function automatic r2_sel_t r2_decode(input logic q0, input logic q_1);
    r2_sel_t sel;
    case ({q0, q_1})
      2'b01:   sel = R2_ADD;
      2'b10:   sel = R2_SUB;
      default: sel = R2_NOP;
    endcase
    return sel;
  endfunction

  // Modified Booth recoding of the overlapping triplet {Q[1], Q[0], q_1}.
  function automatic r4_dig_t r4_decode(input logic [2:0] bits);
    r4_dig_t dig;
    case (bits)
      3'b001, 3'b010: dig = R4_ADD1;
      3'b011:         dig = R4_ADD2;
      3'b100:         dig = R4_SUB2;
      3'b101, 3'b110: dig = R4_SUB1;
      default:        dig = R4_ZERO;
    endcase
    return dig;
  endfunction

  // Radix-2 retires one bit of the (W+1)-bit extended multiplier per step;
  // radix-4 retires two bits of the (W+2)-bit extended multiplier per step.
  function automatic int iter_count(input int w, input bit radix4);
    return radix4 ? (w + 2) / 2 : w + 1;
  endfunction

endpackage

// File: rtl/booth_mult_seq_if.sv
// booth_mult_seq_if: request/result bundle of the Booth multiplier.
//   start, sgn, x, y : request side, driven by the master (requester)
//   s, busy, done    : result side, driven by the slave (multiplier)
//   dbg_state        : current FSM state, for observation only
// Handshake: start is honoured only when the multiplier is in IDLE or DONE;
// sgn/x/y are captured on that same edge and need not be held afterwards.
// busy is high from the cycle after an accepted start through the done
// cycle; done pulses for one cycle when s takes its new value, and s then
// holds until the next done.
// Optional feature macro: BOOTH_RADIX4_EN (no effect on this interface).
interface booth_mult_seq_if #(
  parameter int W = 8
);
  import booth_pkg::*;

  logic           start;
  logic           sgn;
  logic [W-1:0]   x;
  logic [W-1:0]   y;
  logic [2*W-1:0] s;
  logic           busy;
  logic           done;
  state_t         dbg_state;

  modport master (
    output start, sgn, x, y,
    input  s, busy, done, dbg_state
  );

  modport slave (
    input  start, sgn, x, y,
    output s, busy, done, dbg_state
  );

endinterface

// File: rtl/booth_addsub.sv
// booth_addsub: accumulator update unit of the Booth multiplier.
//   a   : current accumulator A (IW bits, two's complement)
//   m   : multiplicand M (IW bits, two's complement)
//   sel : radix-2 select code, or radix-4 digit code
//   sum : new accumulator, IW bits (radix-2) or IW+1 bits (radix-4)
// The shift that follows each step lives in the top level.
// Optional feature macro: BOOTH_RADIX4_EN (adds the +-2M terms and one
// extra adder bit so A+-2M cannot wrap before the 2-bit shift).
module booth_addsub
  import booth_pkg::*;
#(
  parameter int IW = 9
) (
  input  logic [IW-1:0] a,
  input  logic [IW-1:0] m,
`ifdef BOOTH_RADIX4_EN
  input  r4_dig_t       sel,
  output logic [IW:0]   sum
`else
  input  r2_sel_t       sel,
  output logic [IW-1:0] sum
`endif
);

`ifdef BOOTH_RADIX4_EN
  logic [IW:0] a_ext;
  logic [IW:0] m_ext;
  logic [IW:0] m_dbl;

  always_comb begin
    a_ext = {a[IW-1], a};
    m_ext = {m[IW-1], m};
    // |M| < 2^(IW-2), so the left shift keeps the sign in bit IW.
    m_dbl = {m, 1'b0};
    case (sel)
      R4_ADD1: sum = a_ext + m_ext;
      R4_ADD2: sum = a_ext + m_dbl;
      R4_SUB1: sum = a_ext - m_ext;
      R4_SUB2: sum = a_ext - m_dbl;
      default: sum = a_ext;
    endcase
  end
`else
  always_comb begin
    case (sel)
      R2_ADD:  sum = a + m;
      R2_SUB:  sum = a - m;
      default: sum = a;
    endcase
  end
`endif

endmodule

// File: rtl/booth_mult_seq.sv
// booth_mult_seq: sequential Booth multiplier with a start/busy/done handshake.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high reset
//   bus   : booth_mult_seq_if slave port (start, sgn, x, y in; s, busy,
//           done, dbg_state out)
// Operands are extended by one bit (radix-4: two bits) according to sgn,
// so signed and unsigned products share one signed Booth datapath.
// Optional feature macro: BOOTH_RADIX4_EN (modified Booth radix-4,
// (W+2)/2 iterations instead of W+1; W must then be even).
module booth_mult_seq
  import booth_pkg::*;
#(
  parameter int W  = 8,
  parameter int CW = $clog2(W + 3)
) (
  input  logic            clk,
  input  logic            reset,
  booth_mult_seq_if.slave bus
);

`ifdef BOOTH_RADIX4_EN
  localparam bit R4 = 1'b1;
  localparam int IW = W + 2;
  localparam int AW = IW + 1;
`else
  localparam bit R4 = 1'b0;
  localparam int IW = W + 1;
  localparam int AW = IW;
`endif
  localparam int            N   = iter_count(W, R4);
  localparam logic [CW-1:0] N_C = CW'(N);

  state_t          state_q, state_d;
  logic [IW-1:0]   a_q, a_d;
  logic [IW-1:0]   q_q, q_d;
  logic            q1_q, q1_d;
  logic [IW-1:0]   m_q, m_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2*W-1:0]  s_q, s_d;

  logic [IW-1:0]   x_ext;
  logic [IW-1:0]   y_ext;
  logic [AW-1:0]   sum;
  logic [IW-1:0]   a_sh;
  logic [IW-1:0]   q_sh;
  logic            q1_sh;

`ifdef BOOTH_RADIX4_EN
  r4_dig_t sel;
  assign sel = r4_decode({q_q[1:0], q1_q});
`else
  r2_sel_t sel;
  assign sel = r2_decode(q_q[0], q1_q);
`endif

  // Extension bits carry the sign only for signed operands.
  assign x_ext = bus.sgn ? {{(IW-W){bus.x[W-1]}}, bus.x} : {{(IW-W){1'b0}}, bus.x};
  assign y_ext = bus.sgn ? {{(IW-W){bus.y[W-1]}}, bus.y} : {{(IW-W){1'b0}}, bus.y};

  booth_addsub #(
    .IW (IW)
  ) u_addsub (
    .a   (a_q),
    .m   (m_q),
    .sel (sel),
    .sum (sum)
  );

  // Arithmetic right shift of {sum, Q, q_1}; the sign of the new A is replicated.
`ifdef BOOTH_RADIX4_EN
  assign a_sh  = {sum[IW], sum[IW:2]};
  assign q_sh  = {sum[1:0], q_q[IW-1:2]};
  assign q1_sh = q_q[1];
`else
  assign a_sh  = {sum[IW-1], sum[IW-1:1]};
  assign q_sh  = {sum[0], q_q[IW-1:1]};
  assign q1_sh = q_q[0];
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    q1_d    = q1_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    s_d     = s_q;

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          m_d     = y_ext;
          q_d     = x_ext;
          a_d     = '0;
          q1_d    = 1'b0;
          cnt_d   = N_C;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d   = a_sh;
        q_d   = q_sh;
        q1_d  = q1_sh;
        cnt_d = cnt_q - 1'b1;
        // Last step: register the product now so s is valid with done.
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          s_d     = (2*W)'({a_sh, q_sh});
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      m_q     <= '0;
      cnt_q   <= '0;
      s_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      q1_q    <= q1_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
    end
  end

  assign bus.s         = s_q;
  assign bus.done      = (state_q == DONE);
  assign bus.busy      = (state_q == RUN) || (state_q == DONE);
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// tb_booth_mult_seq: directed plus random checks of booth_mult_seq.
// Expected products are queued when an operation is accepted and compared
// when done pulses.
module tb_booth_mult_seq;
  import booth_pkg::*;

  localparam int W = 8;
`ifdef BOOTH_RADIX4_EN
  localparam int N = (W + 2) / 2;
`else
  localparam int N = W + 1;
`endif

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  logic [2*W-1:0] exp_q[$];

  booth_mult_seq_if #(.W(W)) bus ();

  booth_mult_seq #(.W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  function automatic logic [2*W-1:0] model(input logic sg, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic [2*W-1:0] ea;
    logic [2*W-1:0] eb;
    ea = sg ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    eb = sg ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
    return ea * eb;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a request before the next edge, release it just after that edge.
  task automatic drive_start(input logic sg, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [2*W-1:0] e);
    @(negedge clk);
    bus.start = 1'b1;
    bus.sgn   = sg;
    bus.x     = a;
    bus.y     = b;
    @(posedge clk);
    #1;
    exp_q.push_back(e);
    bus.start = 1'b0;
    bus.x     = W'($urandom);
    bus.y     = W'($urandom);
    bus.sgn   = 1'($urandom);
  endtask

  // Called just after the accepting edge; waits (bounded) for done.
  task automatic wait_done(input string tag);
    int             cyc;
    logic [2*W-1:0] e;
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!bus.done && cyc < N + 4);
    check({tag, "_latency"}, 64'(cyc), 64'(N));
    tests++;
    assert (exp_q.size() > 0) else begin
      fails++;
      $error("FAIL %s_queue: observed empty expected entry", tag);
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_s"}, 64'(bus.s), 64'(e));
    end
  endtask

  task automatic after_done(input string tag);
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, 64'(bus.done), 64'(0));
    check({tag, "_busy_off"}, 64'(bus.busy), 64'(0));
  endtask

  task automatic run_op(input string tag, input logic sg, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [2*W-1:0] e);
    drive_start(sg, a, b, e);
    check({tag, "_busy_on"}, 64'(bus.busy), 64'(1));
    wait_done(tag);
    after_done(tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic           rs;
    logic [W-1:0]   rx;
    logic [W-1:0]   ry;
    int             dones;
    tests = 0;
    fails = 0;
    bus.start = 1'b0;
    bus.sgn   = 1'b0;
    bus.x     = '0;
    bus.y     = '0;
    reset     = 1'b1;
    #1;
    check("reset_s", 64'(bus.s), 64'(0));
    check("reset_busy", 64'(bus.busy), 64'(0));
    check("reset_done", 64'(bus.done), 64'(0));
    check("reset_state", 64'(bus.dbg_state), 64'(IDLE));
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Directed products.
    run_op("neg7x5",     1'b1, 8'hF9, 8'h05, 16'hFFDD);
    run_op("ffxff_uns",  1'b0, 8'hFF, 8'hFF, 16'hFE01);
    run_op("ffxff_sgn",  1'b1, 8'hFF, 8'hFF, 16'h0001);
    run_op("m128xm128",  1'b1, 8'h80, 8'h80, 16'h4000);
    run_op("m128x127",   1'b1, 8'h80, 8'h7F, 16'hC080);
    run_op("zero",       1'b1, 8'h00, 8'h9C, 16'h0000);
    run_op("uns_80x7f",  1'b0, 8'h80, 8'h7F, 16'h3F80);

    // start pulsed mid-RUN must be ignored.
    drive_start(1'b0, 8'h02, 8'h05, 16'h000A);
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1;
    bus.x     = 8'h03;
    bus.y     = 8'h03;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("ignore_busy", 64'(bus.busy), 64'(1));
    // Three edges have passed since acceptance; wait_done counts from there.
    begin
      int             cyc;
      logic [2*W-1:0] e;
      cyc = 3;
      while (!bus.done && cyc < N + 4) begin
        @(posedge clk);
        #1;
        cyc++;
      end
      check("ignore_latency", 64'(cyc), 64'(N));
      e = exp_q.pop_front();
      check("ignore_s", 64'(bus.s), 64'(e));
    end
    dones = 0;
    repeat (N + 3) begin
      @(posedge clk);
      #1;
      if (bus.done) dones++;
    end
    check("ignore_no_second_done", 64'(dones), 64'(0));
    check("ignore_idle", 64'(bus.dbg_state), 64'(IDLE));

    // Back-to-back: start held through the DONE cycle.
    drive_start(1'b1, 8'h80, 8'h7F, 16'hC080);
    repeat (N - 1) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1;
    bus.sgn   = 1'b1;
    bus.x     = 8'h04;
    bus.y     = 8'hFE;
    @(posedge clk);
    #1;
    check("b2b_first_done", 64'(bus.done), 64'(1));
    check("b2b_first_s", 64'(bus.s), 64'(exp_q.pop_front()));
    @(posedge clk);
    #1;
    exp_q.push_back(16'hFFF8);
    bus.start = 1'b0;
    check("b2b_gap_busy", 64'(bus.busy), 64'(1));
    check("b2b_gap_done", 64'(bus.done), 64'(0));
    begin
      int cyc;
      int busy_drops;
      cyc = 0;
      busy_drops = 0;
      do begin
        @(posedge clk);
        #1;
        cyc++;
        if (!bus.busy) busy_drops++;
      end while (!bus.done && cyc < N + 4);
      check("b2b_second_latency", 64'(cyc), 64'(N));
      check("b2b_busy_held", 64'(busy_drops), 64'(0));
      check("b2b_second_s", 64'(bus.s), 64'(exp_q.pop_front()));
    end
    after_done("b2b");

    // Asynchronous reset in the middle of a RUN.
    drive_start(1'b0, 8'h55, 8'h33, model(1'b0, 8'h55, 8'h33));
    repeat (3) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("abort_s", 64'(bus.s), 64'(0));
    check("abort_busy", 64'(bus.busy), 64'(0));
    check("abort_done", 64'(bus.done), 64'(0));
    check("abort_state", 64'(bus.dbg_state), 64'(IDLE));
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    run_op("after_abort", 1'b0, 8'h06, 8'h07, 16'h002A);

    // Random operands against the arithmetic model.
    for (int i = 0; i < 8; i++) begin
      rs = 1'($urandom_range(0, 1));
      rx = W'($urandom_range(0, (1 << W) - 1));
      ry = W'($urandom_range(0, (1 << W) - 1));
      run_op($sformatf("rand%0d", i), rs, rx, ry, model(rs, rx, ry));
    end

    check("queue_drained", 64'(exp_q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global guard so a stuck design cannot hang the run.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
